// File: rtl/rf_pkg.sv
// Shared register-file types: address width, the hardwired zero register and the
// writeback queue entry layout.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_search.sv
// Youngest-first lookup of a source register among the occupied writeback entries.
module wb_bypass_search
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t               entries [DEPTH],
    input  logic [DEPTH-1:0]        valid,
    input  logic [PTR_W-1:0]        head,
    input  logic [REG_ADDR_W-1:0]   addr,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    // Walk from head toward tail so a later (younger) match overrides an older one.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        idx_s   = head;
        match_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = head + PTR_W'(k);
            match_s = valid[idx_s] && (addr != X0) && (entries[idx_s].rd == addr);
            hit     = hit | match_s;
            data    = match_s ? entries[idx_s].data : data;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the register file write port, with two bypass lookups
// that expose pending values before they retire.
module regfile_wb_queue
    import rf_pkg::*;
#(
    parameter int  N     = 32,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [N-1:0]          in_data,
    input  logic                  wb_hold,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [N-1:0]          WriteData,
    input  logic [REG_ADDR_W-1:0] byp_addr1,
    input  logic [REG_ADDR_W-1:0] byp_addr2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [N-1:0]          byp_data1,
    output logic [N-1:0]          byp_data2,
    output logic [CNT_W-1:0]      count
);

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               push_s;
    logic               pop_s;
    wb_entry_t          head_s;
    logic [DEPTH-1:0]   valid_s;
    logic [PTR_W-1:0]   offset_s;

    assign count    = count_r;
    assign in_ready = (count_r < CNT_W'(DEPTH));
    // Writes to x0 are acknowledged but never enqueued.
    assign push_s   = in_valid && in_ready && (in_rd != X0);
    assign pop_s    = (count_r != {CNT_W{1'b0}}) && !wb_hold;
    assign head_s   = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful where the occupancy mask is set.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= '{rd: in_rd, data: in_data};
        end
    end

    // Slot i is occupied when its distance from the head is below the count.
    always_comb begin
        valid_s  = '0;
        offset_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset_s   = PTR_W'(i) - rd_ptr_r;
            valid_s[i] = ({1'b0, offset_s} < count_r);
        end
    end

    // Present the head entry to the register file while it is being retired.
    always_comb begin
        if (pop_s) begin
            RegWrite  = 1'b1;
            WriteReg  = head_s.rd;
            WriteData = head_s.data;
        end else begin
            RegWrite  = 1'b0;
            WriteReg  = X0;
            WriteData = '0;
        end
    end

    wb_bypass_search #(.DEPTH(DEPTH)) u_byp1 (
        .entries (mem_r),
        .valid   (valid_s),
        .head    (rd_ptr_r),
        .addr    (byp_addr1),
        .hit     (byp_hit1),
        .data    (byp_data1)
    );

    wb_bypass_search #(.DEPTH(DEPTH)) u_byp2 (
        .entries (mem_r),
        .valid   (valid_s),
        .head    (rd_ptr_r),
        .addr    (byp_addr2),
        .hit     (byp_hit2),
        .data    (byp_data2)
    );

endmodule
